// File: rtl/demux_1x2_buffered_if.sv
`default_nettype none
// ============================================================================
// Module      : demux_1x2_buffered_if
// Description : Stream bundle for the 1:2 buffered demultiplexer. Carries
//               the upstream valid/data/ready handshake, the lane selection
//               controls and both downstream lane handshakes plus occupancy.
// Ports       : dataIn/validIn/readyIn  - upstream stream
//               selector/autoMode       - lane choice controls
//               dataOutN/validOutN/readyOutN, fillN - lane N stream + occupancy
// Revision    : 1.0 - initial release
// ============================================================================
interface demux_1x2_buffered_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic [WIDTH-1:0]         dataIn;
  logic                     validIn;
  logic                     readyIn;
  logic                     selector;
  logic                     autoMode;
  logic [WIDTH-1:0]         dataOut0;
  logic                     validOut0;
  logic                     readyOut0;
  logic [WIDTH-1:0]         dataOut1;
  logic                     validOut1;
  logic                     readyOut1;
  logic [$clog2(DEPTH):0]   fill0;
  logic [$clog2(DEPTH):0]   fill1;

  // Producer/consumer side (stimulus)
  modport master (
    output dataIn, validIn, selector, autoMode, readyOut0, readyOut1,
    input  readyIn, dataOut0, validOut0, dataOut1, validOut1, fill0, fill1
  );

  // Demultiplexer side
  modport slave (
    input  dataIn, validIn, selector, autoMode, readyOut0, readyOut1,
    output readyIn, dataOut0, validOut0, dataOut1, validOut1, fill0, fill1
  );
endinterface
`default_nettype wire

// File: rtl/demux_1x2_buffered.sv
`default_nettype none
// ============================================================================
// Module      : demux_1x2_buffered
// Description : 1-to-2 stream demultiplexer. Each accepted input word is
//               written into the FIFO of the target lane; each lane drains
//               independently under its own ready. Target lane comes from
//               the selector input or from an internal burst ping-pong.
// Ports       : clk    - clock, rising edge
//               reset  - synchronous, active-low reset
//               bus    - demux_1x2_buffered_if.slave stream bundle
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1x2_buffered #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,   // power of two, >= 2
  parameter int BURST = 4    // >= 1
) (
  input  wire logic                clk,
  input  wire logic                reset,
  demux_1x2_buffered_if.slave      bus
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_FW = c_AW + 1;
  localparam int c_BW = (BURST > 1) ? $clog2(BURST) : 1;

  localparam logic [c_BW-1:0] c_BURST_LAST = c_BW'(BURST - 1);
  localparam logic [c_BW-1:0] c_BURST_ONE  = c_BW'(1);
  localparam logic [c_FW-1:0] c_FULL       = c_FW'(DEPTH);
  localparam logic [c_FW-1:0] c_FILL_ONE   = c_FW'(1);
  localparam logic [c_AW-1:0] c_PTR_ONE    = c_AW'(1);

  logic              r_autoSel;
  logic [c_BW-1:0]   r_burstCnt;

  logic              w_tgt;
  logic              w_accept;
  logic [1:0]        w_full;
  logic [1:0]        w_push;
  logic [1:0]        w_pop;
  logic [1:0]        w_vld;
  logic [1:0]        w_rdyOut;
  logic [WIDTH-1:0]  w_head [2];
  logic [c_FW-1:0]   w_fill [2];

  assign w_tgt    = bus.autoMode ? r_autoSel : bus.selector;
  // Only the target lane's full flag gates input; a full lane being popped
  // this cycle still refuses the push (no pass-through).
  assign bus.readyIn = reset & ~w_full[w_tgt];
  assign w_accept    = bus.validIn & bus.readyIn;
  assign w_rdyOut    = {bus.readyOut1, bus.readyOut0};

  generate
    for (genvar n = 0; n < 2; n++) begin : g_lane
      logic [WIDTH-1:0] r_mem [DEPTH];
      logic [c_AW-1:0]  r_wp;
      logic [c_AW-1:0]  r_rp;
      logic [c_FW-1:0]  r_fill;

      assign w_full[n] = (r_fill == c_FULL);
      // Outputs are forced quiet while reset is held, even before the
      // first reset edge has cleared the pointers.
      assign w_vld[n]  = reset & (r_fill != '0);
      assign w_push[n] = w_accept & (w_tgt == 1'(n));
      assign w_pop[n]  = w_vld[n] & w_rdyOut[n];
      assign w_head[n] = w_vld[n] ? r_mem[r_rp] : '0;
      assign w_fill[n] = reset ? r_fill : '0;

      always_ff @(posedge clk) begin
        if (!reset) begin
          r_wp   <= '0;
          r_rp   <= '0;
          r_fill <= '0;
        end else begin
          if (w_push[n]) begin
            r_mem[r_wp] <= bus.dataIn;
            r_wp        <= r_wp + c_PTR_ONE;
          end
          if (w_pop[n]) begin
            r_rp <= r_rp + c_PTR_ONE;
          end
          case ({w_push[n], w_pop[n]})
            2'b10:   r_fill <= r_fill + c_FILL_ONE;
            2'b01:   r_fill <= r_fill - c_FILL_ONE;
            default: r_fill <= r_fill;
          endcase
        end
      end
    end
  endgenerate

  // Burst ping-pong: leaving auto mode rearms it so every entry starts on
  // lane 0 with a fresh burst. A full target lane stalls the stream rather
  // than letting the burst skip over it.
  always_ff @(posedge clk) begin
    if (!reset || !bus.autoMode) begin
      r_autoSel  <= 1'b0;
      r_burstCnt <= '0;
    end else if (w_accept) begin
      if (r_burstCnt == c_BURST_LAST) begin
        r_autoSel  <= ~r_autoSel;
        r_burstCnt <= '0;
      end else begin
        r_burstCnt <= r_burstCnt + c_BURST_ONE;
      end
    end
  end

  assign bus.dataOut0  = w_head[0];
  assign bus.validOut0 = w_vld[0];
  assign bus.fill0     = w_fill[0];
  assign bus.dataOut1  = w_head[1];
  assign bus.validOut1 = w_vld[1];
  assign bus.fill1     = w_fill[1];

endmodule
`default_nettype wire

// File: tb/tb_demux_1x2_buffered.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_1x2_buffered
// Description : Directed self-checking bench for demux_1x2_buffered.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1x2_buffered;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  demux_1x2_buffered_if #(.WIDTH(8), .DEPTH(4)) bus ();

  demux_1x2_buffered #(.WIDTH(8), .DEPTH(4), .BURST(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // ---------------- 1. reset ----------------
    reset         = 1'b0;
    bus.validIn   = 1'b1;
    bus.dataIn    = 8'hFF;
    bus.selector  = 1'b0;
    bus.autoMode  = 1'b0;
    bus.readyOut0 = 1'b0;
    bus.readyOut1 = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_readyIn", 32'(bus.readyIn), 32'd0);
    end
    check("rst_validOut0", 32'(bus.validOut0), 32'd0);
    check("rst_validOut1", 32'(bus.validOut1), 32'd0);
    check("rst_dataOut0", 32'(bus.dataOut0), 32'h00);
    check("rst_dataOut1", 32'(bus.dataOut1), 32'h00);
    check("rst_fill0", 32'(bus.fill0), 32'd0);
    check("rst_fill1", 32'(bus.fill1), 32'd0);
    bus.validIn = 1'b0;
    reset       = 1'b1;
    step();
    check("post_rst_fill0", 32'(bus.fill0), 32'd0);
    check("post_rst_fill1", 32'(bus.fill1), 32'd0);

    // ---------------- 2. manual route ----------------
    bus.selector = 1'b0;
    bus.dataIn   = 8'hA5;
    bus.validIn  = 1'b1;
    #1;
    check("man_readyIn", 32'(bus.readyIn), 32'd1);
    step();
    bus.validIn = 1'b0;
    #1;
    check("man_validOut0", 32'(bus.validOut0), 32'd1);
    check("man_dataOut0", 32'(bus.dataOut0), 32'hA5);
    check("man_validOut1", 32'(bus.validOut1), 32'd0);
    check("man_fill0", 32'(bus.fill0), 32'd1);
    bus.readyOut0 = 1'b1;
    step();
    bus.readyOut0 = 1'b0;
    #1;
    check("man_pop_validOut0", 32'(bus.validOut0), 32'd0);
    check("man_pop_dataOut0", 32'(bus.dataOut0), 32'h00);

    // ---------------- 3. full / backpressure ----------------
    bus.selector = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.dataIn  = 8'(8'h10 + i);
      bus.validIn = 1'b1;
      #1;
      check("bp_readyIn", 32'(bus.readyIn), 32'd1);
      step();
    end
    bus.dataIn = 8'h14;
    #1;
    check("bp_fill1_full", 32'(bus.fill1), 32'd4);
    check("bp_readyIn_full", 32'(bus.readyIn), 32'd0);
    step();
    check("bp_fill1_hold", 32'(bus.fill1), 32'd4);
    bus.selector = 1'b0;
    #1;
    check("bp_readyIn_lane0", 32'(bus.readyIn), 32'd1);
    step();
    bus.validIn = 1'b0;
    #1;
    check("bp_fill0", 32'(bus.fill0), 32'd1);
    check("bp_dataOut0", 32'(bus.dataOut0), 32'h14);
    bus.readyOut1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_drain1", 32'(bus.dataOut1), 32'(8'h10 + i));
      step();
    end
    bus.readyOut1 = 1'b0;
    #1;
    check("bp_drain1_empty", 32'(bus.validOut1), 32'd0);
    bus.readyOut0 = 1'b1;
    step();
    bus.readyOut0 = 1'b0;
    #1;
    check("bp_drain0_empty", 32'(bus.validOut0), 32'd0);

    // ---------------- 4. auto ping-pong ----------------
    bus.autoMode  = 1'b1;
    bus.readyOut0 = 1'b1;
    bus.readyOut1 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus.dataIn  = 8'(i);
      bus.validIn = 1'b1;
      #1;
      check("auto_readyIn", 32'(bus.readyIn), 32'd1);
      step();
      #1;
      if (i <= 4) begin
        check("auto_valid0", 32'(bus.validOut0), 32'd1);
        check("auto_data0", 32'(bus.dataOut0), 32'(i));
      end else begin
        check("auto_valid1", 32'(bus.validOut1), 32'd1);
        check("auto_data1", 32'(bus.dataOut1), 32'(i));
      end
    end
    bus.dataIn = 8'h09;
    step();
    bus.validIn = 1'b0;
    #1;
    check("auto_wrap_valid0", 32'(bus.validOut0), 32'd1);
    check("auto_wrap_data0", 32'(bus.dataOut0), 32'h09);
    check("auto_wrap_valid1", 32'(bus.validOut1), 32'd0);
    step();
    bus.autoMode  = 1'b0;
    bus.readyOut0 = 1'b0;
    bus.readyOut1 = 1'b0;
    step();
    check("auto_drained", 32'(bus.fill0 + bus.fill1), 32'd0);

    // ---------------- 5. full with pop ----------------
    bus.selector = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.dataIn  = 8'(8'h20 + i);
      bus.validIn = 1'b1;
      step();
    end
    check("fp_fill0_full", 32'(bus.fill0), 32'd4);
    bus.dataIn    = 8'h24;
    bus.readyOut0 = 1'b1;
    #1;
    check("fp_readyIn_refused", 32'(bus.readyIn), 32'd0);
    step();
    bus.readyOut0 = 1'b0;
    #1;
    check("fp_fill0_after_pop", 32'(bus.fill0), 32'd3);
    check("fp_readyIn_space", 32'(bus.readyIn), 32'd1);
    check("fp_head", 32'(bus.dataOut0), 32'h21);
    step();
    bus.validIn = 1'b0;
    #1;
    check("fp_fill0_refill", 32'(bus.fill0), 32'd4);
    // push + pop on a non-full lane
    bus.selector = 1'b1;
    bus.dataIn   = 8'h30;
    bus.validIn  = 1'b1;
    step();
    check("pp_fill1_one", 32'(bus.fill1), 32'd1);
    bus.dataIn    = 8'h31;
    bus.readyOut1 = 1'b1;
    step();
    bus.validIn   = 1'b0;
    bus.readyOut1 = 1'b0;
    #1;
    check("pp_fill1_same", 32'(bus.fill1), 32'd1);
    check("pp_data1", 32'(bus.dataOut1), 32'h31);
    bus.readyOut0 = 1'b1;
    bus.readyOut1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("pp_drain0", 32'(bus.dataOut0), 32'(8'h21 + i));
      step();
    end
    bus.readyOut0 = 1'b0;
    bus.readyOut1 = 1'b0;
    check("pp_empty0", 32'(bus.fill0), 32'd0);
    check("pp_empty1", 32'(bus.fill1), 32'd0);

    // ---------------- 6. reset mid-operation ----------------
    bus.autoMode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.dataIn  = 8'(8'h50 + i);
      bus.validIn = 1'b1;
      step();
    end
    bus.validIn   = 1'b0;
    bus.readyOut0 = 1'b1;
    step();
    bus.readyOut0 = 1'b0;
    #1;
    check("mid_fill0", 32'(bus.fill0), 32'd3);
    check("mid_fill1", 32'(bus.fill1), 32'd2);
    reset = 1'b0;
    #1;
    check("mid_rst_readyIn", 32'(bus.readyIn), 32'd0);
    step();
    reset = 1'b1;
    #1;
    check("mid_fill0_clr", 32'(bus.fill0), 32'd0);
    check("mid_fill1_clr", 32'(bus.fill1), 32'd0);
    check("mid_valid_clr", 32'({bus.validOut1, bus.validOut0}), 32'd0);
    for (int i = 0; i < 4; i++) begin
      bus.dataIn  = 8'(8'h40 + i);
      bus.validIn = 1'b1;
      step();
    end
    check("mid_burst_fill0", 32'(bus.fill0), 32'd4);
    check("mid_burst_fill1", 32'(bus.fill1), 32'd0);
    check("mid_burst_head", 32'(bus.dataOut0), 32'h40);
    bus.dataIn = 8'h44;
    step();
    bus.validIn = 1'b0;
    #1;
    check("mid_toggle_fill1", 32'(bus.fill1), 32'd1);
    check("mid_toggle_data1", 32'(bus.dataOut1), 32'h44);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/demux_1x2_buffered.md
Name: demux_1x2_buffered

Overview:
- 1-to-2 stream demultiplexer: the fan-out counterpart of the 2:1 valid/data mux.
- Routes an 8-bit valid/data input stream to one of two output lanes.
- Each lane has its own small FIFO with ready backpressure, so a stalled lane never blocks the other.
- Lane choice comes from an external selector, or from an automatic burst-based ping-pong mode.

Parameters:
- WIDTH, 8: data width of input and both lanes.
- DEPTH, 4: entries per lane FIFO. Power of two, minimum 2.
- BURST, 4: accepted words per lane before the lane toggles in auto mode. Minimum 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- dataIn  input  WIDTH  input word.
- validIn  input  1  input word valid.
- readyIn  output  1  block can accept a word into the currently targeted lane.
- selector  input  1  target lane in manual mode (0 = lane 0, 1 = lane 1).
- autoMode  input  1  1 = internal burst ping-pong selects the lane; 0 = selector selects the lane.
- dataOut0  output  WIDTH  lane 0 head word.
- validOut0  output  1  lane 0 holds at least one word.
- readyOut0  input  1  lane 0 consumer accepts the head word.
- dataOut1  output  WIDTH  lane 1 head word.
- validOut1  output  1  lane 1 holds at least one word.
- readyOut1  input  1  lane 1 consumer accepts the head word.
- fill0  output  clog2(DEPTH)+1  lane 0 occupancy.
- fill1  output  clog2(DEPTH)+1  lane 1 occupancy.

Behaviour:
- Reset (reset=0 at a clock edge) clears:
  - both FIFO read/write pointers and occupancies;
  - autoSel and burstCnt.
  While reset=0:
  - readyIn=0;
  - validOut0=validOut1=0 and dataOut0=dataOut1=0;
  - fill0=fill1=0.
  Reset mid-operation discards all buffered words, with no partial drain.
- Target lane: tgt = autoMode ? autoSel : selector. tgt is combinational and sampled every cycle.
- readyIn = reset & !full(tgt). It depends only on the target lane's full flag; the other lane's state has no effect.
- Push: on an edge with validIn=1 and readyIn=1, dataIn is written to lane tgt and that lane's fill increments.
  - With validIn=1 and readyIn=0, the word is not taken. The upstream source must hold it.
- Pop on lane N: on an edge with validOutN=1 and readyOutN=1, the head is removed and fillN decrements.
- Simultaneous push and pop on the same non-full lane: both occur and fill is unchanged.
- Full lane: readyIn=0 even if a pop happens in the same cycle. There is no pass-through into a full FIFO; the push is accepted the cycle after space appears.
- Latency: a word accepted at edge k is visible on dataOutN with validOutN=1 in the cycle after edge k.
  - No combinational path from dataIn/validIn to any lane output.
  - Lane outputs are driven from storage and registered pointers only.
- validOutN = (fillN != 0).
- dataOutN:
  - = FIFO head when validOutN=1;
  - = 0 when validOutN=0, which keeps outputs deterministic for the bench.
- FIFO ordering: strict per-lane FIFO order. Pointers wrap modulo DEPTH. Occupancy range 0..DEPTH.
- Auto mode:
  - burstCnt counts accepted pushes in auto mode.
  - On an accepted push with burstCnt == BURST-1: autoSel toggles and burstCnt returns to 0.
  - Otherwise an accepted push increments burstCnt.
  - No push: hold both values.
  - autoMode=0 at an edge: autoSel and burstCnt are cleared to 0, so every entry into auto mode starts on lane 0 with a fresh burst.
- Stalls: a stalled lane (readyOutN=0) only blocks input when it is the target and full. In auto mode this stalls the whole input stream until space frees; the burst does not skip a full lane.
- selector changes are allowed on any cycle and take effect for that cycle's push decision.

Test Plan:
1. Reset: reset=0 for 3 cycles with validIn=1, dataIn=0xFF -> readyIn=0, validOut0/1=0, dataOut0/1=0x00, fill0/1=0. Nothing is stored after release.
2. Manual route: autoMode=0, selector=0, push 0xA5 with readyOut0=0.
   - Next cycle: validOut0=1, dataOut0=0xA5, validOut1=0, fill0=1.
   - Raise readyOut0: one cycle later validOut0=0, dataOut0=0x00.
3. Full/backpressure: selector=1, readyOut1=0, present 0x10..0x14.
   - 0x10..0x13 accepted; fill1=4; readyIn=0 on 0x14.
   - Switch selector=0 -> readyIn=1 and 0x14 lands in lane 0.
   - Drain lane 1 -> order 0x10,0x11,0x12,0x13.
4. Auto ping-pong: autoMode=1, BURST=4, both readys=1, stream 0x01..0x08 back-to-back -> lane 0 emits 01,02,03,04 and lane 1 emits 05,06,07,08, each 1 cycle after acceptance. autoSel is back at 0 after word 8.
5. Full with pop: lane 0 full, pulse readyOut0 with validIn=1, selector=0.
   - That cycle: pop occurs, push refused (readyIn=0).
   - Next cycle: readyIn=1, word accepted, fill0 back to 4.
   - Separately, on a non-full lane, push+pop in the same cycle -> fill unchanged.
6. Reset mid-operation: fill0=3, fill1=2, autoMode=1, burstCnt=2, then pull reset=0 for 1 cycle -> fill0=fill1=0, validOuts 0. After release, the next push goes to lane 0 and starts a fresh 4-word burst.
